// File: rtl/load_rr_arbiter_pkg.sv
// Shared constants and types for the round-robin load arbiter.
// Lane count, state encoding and the legal range of the hold limit.
package load_rr_arbiter_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  localparam int HOLD_MIN = 1;
  localparam int HOLD_MAX = 15;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Lane after p in the rotation.
  function automatic logic [SEL_W-1:0] next_lane(input logic [SEL_W-1:0] p);
    return p + 2'd1;
  endfunction

endpackage

// File: rtl/DMux4Way.sv
// Four-way demultiplexer: routes in to output a/b/c/d chosen by sel.
module DMux4Way (
  input  logic       in,
  input  logic [1:0] sel,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d
);

  assign a = in & (sel == 2'd0);
  assign b = in & (sel == 2'd1);
  assign c = in & (sel == 2'd2);
  assign d = in & (sel == 2'd3);

endmodule

// File: rtl/load_rr_arbiter_rr_pick4.sv
// Combinational round-robin pick: first requesting lane scanning
// ptr, ptr+1, ptr+2, ptr+3 (mod 4).
module rr_pick4
  import load_rr_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] pick,
  output logic             any
);

  logic [SEL_W-1:0] idx [N_REQ];
  logic [N_REQ-1:0] hit;

  // hit[k] means the lane k steps after ptr is requesting.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_scan
    assign idx[gi] = ptr + SEL_W'(gi);
    assign hit[gi] = req[idx[gi]];
  end

  always_comb begin
    pick = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (hit[i]) begin
        pick = idx[i];
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/load_rr_arbiter.sv
// Round-robin arbiter sharing one write path between four requesters,
// with a per-grant burst limit of HOLD consecutive load cycles.
module load_rr_arbiter
  import load_rr_arbiter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int HOLD  = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] wdata,
  output logic [N_REQ-1:0]       gnt,
  output logic [SEL_W-1:0]       sel,
  output logic                   load,
  output logic [WIDTH-1:0]       out,
  output logic                   busy
);

  localparam logic [3:0] CNT_INIT = 4'(HOLD - 1);

  state_t           state_reg;
  logic [SEL_W-1:0] ptr_reg;
  logic [3:0]       cnt_reg;
  logic [SEL_W-1:0] sel_reg;
  logic             load_reg;
  logic [WIDTH-1:0] out_reg;

  logic [WIDTH-1:0] lane [N_REQ];
  logic [SEL_W-1:0] scan_ptr;
  logic [SEL_W-1:0] pick;
  logic             any;
  logic             keep;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
    assign lane[gi] = wdata[gi*WIDTH +: WIDTH];
  end

  // On release the rescan must already use the rotated pointer, so the
  // next grant follows on the same edge without a bubble.
  assign scan_ptr = (state_reg == ST_GRANT) ? next_lane(sel_reg) : ptr_reg;
  assign keep     = req[sel_reg] && (cnt_reg != 4'd0);

  rr_pick4 u_pick (
    .req  (req),
    .ptr  (scan_ptr),
    .pick (pick),
    .any  (any)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      ptr_reg   <= '0;
      cnt_reg   <= '0;
      sel_reg   <= '0;
      load_reg  <= 1'b0;
      out_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (any) begin
            sel_reg   <= pick;
            load_reg  <= 1'b1;
            out_reg   <= lane[pick];
            cnt_reg   <= CNT_INIT;
            state_reg <= ST_GRANT;
          end else begin
            load_reg <= 1'b0;
          end
        end
        ST_GRANT: begin
          if (keep) begin
            load_reg <= 1'b1;
            out_reg  <= lane[sel_reg];
            cnt_reg  <= cnt_reg - 4'd1;
          end else begin
            ptr_reg <= next_lane(sel_reg);
            if (any) begin
              sel_reg  <= pick;
              load_reg <= 1'b1;
              out_reg  <= lane[pick];
              cnt_reg  <= CNT_INIT;
            end else begin
              // sel and out hold their last values while idle.
              load_reg  <= 1'b0;
              state_reg <= ST_IDLE;
            end
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          load_reg  <= 1'b0;
        end
      endcase
    end
  end

  DMux4Way u_gnt (
    .in  (load_reg),
    .sel (sel_reg),
    .a   (gnt[0]),
    .b   (gnt[1]),
    .c   (gnt[2]),
    .d   (gnt[3])
  );

  assign sel  = sel_reg;
  assign load = load_reg;
  assign out  = out_reg;
  assign busy = (state_reg == ST_GRANT);

endmodule
